// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 16x-oversampled UART receiver, DATA_BITS data bits LSB first plus
//            one stop bit; even parity added when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 o_parity_err
`endif
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd5;
`endif

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);

  logic                 rx_meta;
  logic                 rx_s;
  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [3:0]           tick_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  logic mid_start;
  logic mid_bit;
  logic last_data;
  logic stop_ok;
  logic stop_bad;

  // Two-stage synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!rx_s) state_nxt = ST_START;
      ST_START:  if (mid_start) state_nxt = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
      ST_DATA:   if (last_data) state_nxt = ST_PARITY;
      ST_PARITY: if (mid_bit) state_nxt = ST_STOP;
`else
      ST_DATA:   if (last_data) state_nxt = ST_STOP;
`endif
      ST_STOP:   if (mid_bit) state_nxt = rx_s ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rx_s) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mid_start = (state == ST_START) && i_rx_tick && (tick_cnt == 4'd7);
    mid_bit   = i_rx_tick && (tick_cnt == 4'd15);
    last_data = (state == ST_DATA) && mid_bit && (bit_cnt == LAST_BIT);
    stop_ok   = (state == ST_STOP) && mid_bit && rx_s;
    stop_bad  = (state == ST_STOP) && mid_bit && !rx_s;
    o_busy    = (state != ST_IDLE);
  end

  // The tick counter restarts at mid start bit so later samples land mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt    <= 4'd0;
      bit_cnt     <= 4'd0;
      shift_reg   <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= stop_ok;
      o_frame_err <= stop_bad;

      if (state == ST_IDLE || state == ST_BREAK) begin
        tick_cnt <= 4'd0;
      end else if (i_rx_tick) begin
        tick_cnt <= mid_start ? 4'd0 : tick_cnt + 4'd1;
      end

      if (mid_start) begin
        bit_cnt <= 4'd0;
      end else if (state == ST_DATA && mid_bit) begin
        bit_cnt   <= bit_cnt + 4'd1;
        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      end

      if (stop_ok || stop_bad) begin
        o_data <= shift_reg;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  // Even parity: data bits plus parity bit must hold an even number of ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit      <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      if (state == ST_PARITY && mid_bit) begin
        par_bit <= rx_s;
      end
      o_parity_err <= (stop_ok || stop_bad) && ((^shift_reg) ^ par_bit);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx; directed scenarios plus random
//            frames compared against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int DW       = 8;
  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit PAR_EN     = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit PAR_EN     = 1'b0;
`endif
  // Mid-stop sample point after the start edge, plus synchroniser delay.
  localparam int LAT_NOM = FRAME_BITS * BIT_CLKS - BIT_CLKS / 2 + 2;
  localparam int LAT_TOL = 6;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          rx_tick = 1'b0;
  logic          rx      = 1'b1;
  logic [DW-1:0] data;
  logic          valid;
  logic          ferr;
  logic          busy;
  logic          perr;

  uart_rx #(.DATA_BITS(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx_tick   (rx_tick),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .o_frame_err (ferr),
    .o_busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(perr)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One tick every 4 clocks.
  initial begin
    forever begin
      @(negedge clk);
      rx_tick = (cyc % 4 == 0);
    end
  end

  typedef struct {
    bit          v;
    bit          fe;
    bit          pe;
    logic [DW-1:0] d;
    int          cyc;
  } evt_t;

  evt_t evq[$];

  always @(negedge clk) begin
    evt_t e;
    if (!rst && (valid || ferr || perr)) begin
      e.v   = valid;
      e.fe  = ferr;
      e.pe  = perr;
      e.d   = data;
      e.cyc = cyc;
      evq.push_back(e);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input bit b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Called on a negedge; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [DW-1:0] d, input bit stop, input bit par,
                            output int t0);
    rx = 1'b0;
    t0 = cyc;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (PAR_EN) send_bit(par);
    send_bit(stop);
  endtask

  // Reference: each frame yields exactly one strobe event at mid-stop time.
  task automatic check_frame(input string tag, input logic [DW-1:0] d, input bit stop_ok,
                             input bit perr_exp, input int t0);
    int lat;
    check($sformatf("%s_count", tag), evq.size(), 1);
    if (evq.size() > 0) begin
      lat = evq[0].cyc - t0;
      check($sformatf("%s_valid", tag), evq[0].v, stop_ok);
      check($sformatf("%s_ferr", tag), evq[0].fe, !stop_ok);
      check($sformatf("%s_perr", tag), evq[0].pe, perr_exp);
      check($sformatf("%s_data", tag), evq[0].d, d);
      check($sformatf("%s_lat%0d", tag, lat),
            (lat >= LAT_NOM - LAT_TOL) && (lat <= LAT_NOM + LAT_TOL), 1);
    end
    evq.delete();
  endtask

  logic [DW-1:0] b2b [3] = '{8'h00, 8'hFF, 8'h55};

  initial begin
    int            t0;
    logic [DW-1:0] d;
    bit            stop;
    bit            par;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_ferr", ferr, 0);
    check("rst_perr", perr, 0);
    check("rst_busy", busy, 0);
    check("rst_data", data, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    send_frame(8'hA5, 1'b1, 1'b0, t0);
    check_frame("a5", 8'hA5, 1'b1, 1'b0, t0);

    for (int i = 0; i < 3; i++) begin
      d = b2b[i];
      send_frame(d, 1'b1, ^d, t0);
      check_frame($sformatf("b2b%0d", i), d, 1'b1, 1'b0, t0);
    end

    repeat (10) @(negedge clk);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_busy", busy, 1);
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("glitch_idle", busy, 0);
    check("glitch_evts", evq.size(), 0);

    send_frame(8'h3C, 1'b0, 1'b0, t0);
    check_frame("ferr", 8'h3C, 1'b0, 1'b0, t0);
    repeat (20 * BIT_CLKS) @(negedge clk);
    check("brk_busy", busy, 1);
    check("brk_evts", evq.size(), 0);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("brk_idle", busy, 0);
    check("brk_data_hold", data, 8'h3C);

    // 0x81 LSB first: start, 1, 0, 0 then reset.
    repeat (BIT_CLKS) @(negedge clk);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    check("mr_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    check("mr_busy", busy, 0);
    check("mr_data", data, 0);
    check("mr_valid", valid, 0);
    check("mr_ferr", ferr, 0);
    @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6 * BIT_CLKS) @(negedge clk);
    check("mr_evts", evq.size(), 0);
    send_frame(8'h7E, 1'b1, 1'b0, t0);
    check_frame("7e", 8'h7E, 1'b1, 1'b0, t0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, t0);
    check_frame("par_good", 8'h07, 1'b1, 1'b0, t0);
    send_frame(8'h07, 1'b1, 1'b0, t0);
    check_frame("par_bad", 8'h07, 1'b1, 1'b1, t0);
`endif

    for (int n = 0; n < 24; n++) begin
      d    = DW'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par  = ^d;
      if ($urandom_range(0, 3) == 0) par = ~par;
      send_frame(d, stop, par, t0);
      rx = 1'b1;
      check_frame($sformatf("rnd%0d", n), d, stop, PAR_EN ? (^d ^ par) : 1'b0, t0);
      // A bad stop leaves the receiver in BREAK until the line is seen high.
      if (stop) repeat ($urandom_range(0, 150)) @(negedge clk);
      else      repeat ($urandom_range(BIT_CLKS, 150)) @(negedge clk);
    end

    repeat (BIT_CLKS) @(negedge clk);
    check("final_busy", busy, 0);
    check("final_evts", evq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
